// File: rtl/ggt_pkg.sv
// Shared constants for the binary GCD engine: default widths, FSM state
// encoding, and the accept-to-valid latency bound the requester may rely on.
// Used by ggt_stein_if, ggt_stein_step, ggt_stein and the bench.
package ggt_pkg;

  localparam int W_DEF  = 16;
  localparam int CW_DEF = 5;

  // FSM encoding; DONE accepts a new request exactly like IDLE.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_REDUCE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Worst-case accept-to-valid clocks and the requester's give-up bound.
  function automatic int lat_bound(input int w);
    return 3 * w + 3;
  endfunction

  localparam int LAT_MAX      = 3 * W_DEF + 3;
  localparam int TIMEOUT_CLKS = 4 * W_DEF;

endpackage

// File: rtl/ggt_stein_if.sv
// Request/result bundle between a GCD requester (master) and engine (slave).
// Signals: start_i, Zahl1_i, Zahl2_i (to engine); ergebnis, valid, busy
// (from engine); zyklen (from engine) only when GGT_CYCLE_COUNT_EN is defined.
interface ggt_stein_if #(
  parameter int W = 16
) ();

  logic         start_i;
  logic [W-1:0] Zahl1_i;
  logic [W-1:0] Zahl2_i;
  logic [W-1:0] ergebnis;
  logic         valid;
  logic         busy;
`ifdef GGT_CYCLE_COUNT_EN
  logic [15:0]  zyklen;

  modport master (output start_i, Zahl1_i, Zahl2_i,
                  input  ergebnis, valid, busy, zyklen);
  modport slave  (input  start_i, Zahl1_i, Zahl2_i,
                  output ergebnis, valid, busy, zyklen);
`else
  modport master (output start_i, Zahl1_i, Zahl2_i,
                  input  ergebnis, valid, busy);
  modport slave  (input  start_i, Zahl1_i, Zahl2_i,
                  output ergebnis, valid, busy);
`endif

endinterface

// File: rtl/ggt_stein_step.sv
// One combinational Stein reduction step on two nonzero operands.
// Ports: a, b in; a_nxt, b_nxt out (next operand values); eq out (a == b).
// Priority: equal, a even, b even, then halve the difference of larger minus smaller.
module ggt_stein_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] a_nxt,
  output logic [W-1:0] b_nxt,
  output logic         eq
);

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    eq    = (a == b);
    if (!eq) begin
      if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (a > b) begin
        // Both odd: the difference is even, so halving loses nothing.
        a_nxt = (a - b) >> 1;
      end else begin
        b_nxt = (b - a) >> 1;
      end
    end
  end

endmodule

// File: rtl/ggt_stein.sv
// Binary (Stein) GCD engine: one operand pair per accepted start, result held with valid.
// Ports: clk, rst (async active-low), bus (ggt_stein_if.slave: start_i, Zahl1_i, Zahl2_i,
// ergebnis, valid, busy). Optional GGT_CYCLE_COUNT_EN adds bus.zyklen busy-cycle counter.
module ggt_stein
  import ggt_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  ggt_stein_if.slave  bus
);

  logic [2:0]    state;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [CW-1:0] k;
  logic [W-1:0]  ergebnis;
  logic          valid;
  logic          busy;

  logic [W-1:0]  a_nxt;
  logic [W-1:0]  b_nxt;
  logic          eq;
  logic          accept;

  assign accept = bus.start_i && ((state == ST_IDLE) || (state == ST_DONE));

  ggt_stein_step #(.W(W)) u_step (
    .a     (a),
    .b     (b),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .eq    (eq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      a        <= '0;
      b        <= '0;
      k        <= '0;
      ergebnis <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else if (accept) begin
      a     <= bus.Zahl1_i;
      b     <= bus.Zahl2_i;
      k     <= '0;
      valid <= 1'b0;
      busy  <= 1'b1;
      state <= ST_CHECK;
    end else begin
      case (state)
        ST_CHECK: begin
          // gcd(0,x) = x covers gcd(0,0) = 0 as well.
          if (a == '0) begin
            ergebnis <= b;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end else if (b == '0) begin
            ergebnis <= a;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Strip common factors of two; k remembers how many to restore.
          if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else begin
            state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (eq) begin
            // a divides the k-stripped operands, so a<<k cannot overflow W bits.
            ergebnis <= a << k;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end else begin
            a <= a_nxt;
            b <= b_nxt;
          end
        end
        ST_IDLE, ST_DONE: begin
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ergebnis = ergebnis;
  assign bus.valid    = valid;
  assign bus.busy     = busy;

`ifdef GGT_CYCLE_COUNT_EN
  logic [15:0] zyklen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zyklen <= '0;
    end else if (accept) begin
      zyklen <= '0;
    end else if (busy && (zyklen != 16'hFFFF)) begin
      zyklen <= zyklen + 16'd1;
    end
  end

  assign bus.zyklen = zyklen;
`endif

endmodule

// File: tb/tb_ggt_stein.sv
// Directed bench for ggt_stein: known GCD vectors, zero operands, start while busy,
// and asynchronous reset during a reduction.
module tb_ggt_stein;
  import ggt_pkg::*;

  logic clk;
  logic rst;

  int checks;
  int errors;

  ggt_stein_if #(.W(16)) bus ();

  ggt_stein #(.W(16), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for valid, check result and latency.
  // exact_lat > 0 demands that latency; otherwise the worst-case bound applies.
  task automatic run_gcd(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp, input int exact_lat);
    int n;
    bus.start_i = 1'b1;
    bus.Zahl1_i = x;
    bus.Zahl2_i = y;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.Zahl1_i = 16'hDEAD;
    bus.Zahl2_i = 16'hBEEF;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    n = 1;
    while (!bus.valid && n < TIMEOUT_CLKS) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
    chk({tag, "_res"}, {16'd0, bus.ergebnis}, {16'd0, exp});
    if (exact_lat > 0) chk({tag, "_lat"}, n, exact_lat);
    else               chk({tag, "_lat_ok"}, {31'd0, (n <= lat_bound(16))}, 32'd1);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    bus.start_i = 1'b0;
    bus.Zahl1_i = '0;
    bus.Zahl2_i = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_res",   {16'd0, bus.ergebnis}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_gcd("t1",    16'd24255, 16'd12540, 16'd165,   0);
    run_gcd("t2a",   16'd48,    16'd18,    16'd6,     0);
    run_gcd("t2b",   16'd32768, 16'd16384, 16'd16384, 0);
    run_gcd("t2c",   16'd65535, 16'd65535, 16'd65535, 0);
    run_gcd("t2d",   16'd17,    16'd5,     16'd1,     0);
    run_gcd("t2e",   16'd40000, 16'd60000, 16'd20000, 0);
    run_gcd("t2f",   16'd65535, 16'd1,     16'd1,     0);

    // Result must stay put while no new request arrives.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", {31'd0, bus.valid}, 32'd1);
    chk("hold_res",   {16'd0, bus.ergebnis}, 32'd1);

    run_gcd("t3a", 16'd0, 16'd7, 16'd7, 2);
    run_gcd("t3b", 16'd9, 16'd0, 16'd9, 2);
    run_gcd("t3c", 16'd0, 16'd0, 16'd0, 2);

    // Start while busy must be ignored.
    bus.start_i = 1'b1;
    bus.Zahl1_i = 16'd48;
    bus.Zahl2_i = 16'd18;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.Zahl1_i = 16'd7;
    bus.Zahl2_i = 16'd5;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    chk("t4_busy", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (!bus.valid && n < TIMEOUT_CLKS) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_valid", {31'd0, bus.valid}, 32'd1);
    chk("t4_res",   {16'd0, bus.ergebnis}, 32'd6);

    // Asynchronous reset in the middle of a reduction.
    bus.start_i = 1'b1;
    bus.Zahl1_i = 16'd24255;
    bus.Zahl2_i = 16'd12540;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("t5_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_valid", {31'd0, bus.valid}, 32'd0);
    chk("t5_res",   {16'd0, bus.ergebnis}, 32'd0);
    chk("t5_busy",  {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_gcd("t5b", 16'd100, 16'd75, 16'd25, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
